rf_write_arbiter: RTL and testbench

- Shares the register file's single write port, a 4-to-16 select decoder with load enable, among NREQ write requesters.
- Round-robin arbitration; one winner per write slot.
- Drives the decoder select, the load enable and the write data.
- Sits between the execute/writeback sources and the register file write port.

---
 rtl/rf_write_arbiter.sv | 133 +++++++++++++
 tb/tb_rf_write_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_arbiter
// Brief    : Round-robin arbiter sharing the register-file write port among
//            NREQ requesters. Optional RF_WR_STATS_EN adds drop_cnt.
// Revision : 1.0
// ============================================================================
module rf_write_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 4,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [AW-1:0]        wr_sel,
    output logic                 wr_ld,
    output logic [DW-1:0]        wr_data,
    output logic                 busy
`ifdef RF_WR_STATS_EN
    ,
    output logic [15:0]          drop_cnt
`endif
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_RECOVER = 2'd2
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_rr_ptr;

    logic            w_found;
    logic [PW-1:0]   w_win;
    logic [PW-1:0]   w_next_ptr;
    logic [AW-1:0]   w_win_addr;
    logic [DW-1:0]   w_win_data;

    // Scan upward from the round-robin pointer, wrapping at NREQ-1.
    always_comb begin : p_pick
        int idx;
        w_found = 1'b0;
        w_win   = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_win   = PW'(idx);
            end
        end
    end

    assign w_win_addr = req_addr[int'(w_win)*AW +: AW];
    assign w_win_data = req_data[int'(w_win)*DW +: DW];
    assign w_next_ptr = (w_win == PW'(NREQ-1)) ? '0 : w_win + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            gnt      <= '0;
            wr_sel   <= '0;
            wr_ld    <= 1'b0;
            wr_data  <= '0;
            busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        gnt      <= NREQ'(1) << w_win;
                        wr_sel   <= w_win_addr;
                        wr_data  <= w_win_data;
                        // Register 0 is hardwired: grant to release the requester, but never load.
                        wr_ld    <= (w_win_addr != '0);
                        r_rr_ptr <= w_next_ptr;
                        busy     <= 1'b1;
                        r_state  <= S_WRITE;
                    end else begin
                        gnt   <= '0;
                        wr_ld <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                S_WRITE: begin
                    gnt     <= '0;
                    wr_ld   <= 1'b0;
                    busy    <= 1'b1;
                    r_state <= S_RECOVER;
                end
                S_RECOVER: begin
                    // Requests are ignored here, so a late deassert cannot double-grant.
                    gnt     <= '0;
                    wr_ld   <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    gnt     <= '0;
                    wr_ld   <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef RF_WR_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (r_state == S_IDLE && w_found && w_win_addr == '0
                     && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

    a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_ld_has_gnt : assert property (@(posedge clk) disable iff (!rst_n) wr_ld |-> |gnt);

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_write_arbiter
// Brief    : Scoreboard bench for rf_write_arbiter (NREQ=2, AW=4, DW=32).
// Revision : 1.0
// ============================================================================
module tb_rf_write_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 4;
    localparam int DW   = 32;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     gnt;
    logic [AW-1:0]       wr_sel;
    logic                wr_ld;
    logic [DW-1:0]       wr_data;
    logic                busy;
`ifdef RF_WR_STATS_EN
    logic [15:0]         drop_cnt;
`endif

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic [AW-1:0]   sel;
        logic [DW-1:0]   data;
        logic            ld;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   ld_count = 0;

    rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .gnt      (gnt),
        .wr_sel   (wr_sel),
        .wr_ld    (wr_ld),
        .wr_data  (wr_data),
        .busy     (busy)
`ifdef RF_WR_STATS_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [NREQ-1:0] g, input logic [AW-1:0] s,
                        input logic [DW-1:0] d, input logic l);
        exp_t e;
        e.gnt = g; e.sel = s; e.data = d; e.ld = l;
        sb.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    // Returns the number of negedges until a grant is visible, -1 on timeout.
    task automatic wait_gnt(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (gnt != '0) begin
                lat = i;
                return;
            end
        end
        check("gnt_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Output monitor: every grant or load must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && (gnt != '0 || wr_ld)) begin
            if (wr_ld) ld_count++;
            if (sb.size() == 0) begin
                check("unexpected_gnt", {gnt, wr_ld}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_gnt",  gnt,     e.gnt);
                check("sb_sel",  wr_sel,  e.sel);
                check("sb_data", wr_data, e.data);
                check("sb_ld",   wr_ld,   e.ld);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int t_prev;
        int ld_base;
        rst_n    = 1'b0;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        #3;
        check("rst_gnt",  gnt,     64'd0);
        check("rst_ld",   wr_ld,   64'd0);
        check("rst_sel",  wr_sel,  64'd0);
        check("rst_data", wr_data, 64'd0);
        check("rst_busy", busy,    64'd0);
`ifdef RF_WR_STATS_EN
        check("rst_drop", drop_cnt, 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single write, latency and busy window
        set_req(0, 4'h5, 32'hDEADBEEF);
        req = 2'b01;
        push(2'b01, 4'h5, 32'hDEADBEEF, 1'b1);
        wait_gnt(10, lat);
        check("t1_latency", lat, 64'd1);
        check("t1_busy_write", busy, 64'd1);
        req = 2'b00;
        @(negedge clk);
        check("t1_ld_recover", wr_ld, 64'd0);
        check("t1_busy_recover", busy, 64'd1);
        @(negedge clk);
        check("t1_ld_idle", wr_ld, 64'd0);
        check("t1_busy_idle", busy, 64'd0);

        // 2: both requesters held, alternating grants 3 cycles apart
        do_reset();
        set_req(0, 4'h3, 32'h11111111);
        set_req(1, 4'h7, 32'h22222222);
        req = 2'b11;
        push(2'b01, 4'h3, 32'h11111111, 1'b1);
        push(2'b10, 4'h7, 32'h22222222, 1'b1);
        push(2'b01, 4'h3, 32'h11111111, 1'b1);
        push(2'b10, 4'h7, 32'h22222222, 1'b1);
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(10, lat);
            if (i > 0) check("t2_spacing", cyc - t_prev, 64'd3);
            t_prev = cyc;
        end
        req = 2'b00;
        repeat (3) @(negedge clk);

        // 3: write to register 0 is granted without a load
`ifdef RF_WR_STATS_EN
        check("t3_drop_before", drop_cnt, 64'd0);
`endif
        set_req(1, 4'h0, 32'hCAFEF00D);
        req = 2'b10;
        push(2'b10, 4'h0, 32'hCAFEF00D, 1'b0);
        wait_gnt(10, lat);
        req = 2'b00;
`ifdef RF_WR_STATS_EN
        check("t3_drop_after", drop_cnt, 64'd1);
`endif
        repeat (3) @(negedge clk);

        // 4: late deassert through RECOVER yields a single grant
        ld_base = ld_count;
        set_req(0, 4'h9, 32'h0BADC0DE);
        req = 2'b01;
        push(2'b01, 4'h9, 32'h0BADC0DE, 1'b1);
        wait_gnt(10, lat);
        @(negedge clk);
        req = 2'b00;
        repeat (6) @(negedge clk);
        check("t4_ld_pulses", ld_count - ld_base, 64'd1);

        // 5: async reset during WRITE, then rr_ptr must restart at 0
        set_req(0, 4'h6, 32'h66666666);
        req = 2'b01;
        push(2'b01, 4'h6, 32'h66666666, 1'b1);
        wait_gnt(10, lat);
        #1 rst_n = 1'b0;
        #1;
        check("t5_gnt_async", gnt, 64'd0);
        check("t5_ld_async", wr_ld, 64'd0);
        check("t5_busy_async", busy, 64'd0);
        set_req(1, 4'h2, 32'h22220000);
        req = 2'b11;
        push(2'b01, 4'h6, 32'h66666666, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_gnt(10, lat);
        check("t5_latency", lat, 64'd1);
        req = 2'b10;
        push(2'b10, 4'h2, 32'h22220000, 1'b1);
        wait_gnt(10, lat);
        req = 2'b00;
        repeat (3) @(negedge clk);

        // 6: sweep wr_sel 1..15 through requester 0 back-to-back
        ld_base = ld_count;
        t_prev  = 0;
        for (int a = 1; a <= 15; a++) begin
            set_req(0, AW'(a), DW'(a) * 32'h01010101);
            req = 2'b01;
            push(2'b01, AW'(a), DW'(a) * 32'h01010101, 1'b1);
            wait_gnt(10, lat);
            if (a > 1) check("t6_gap_ge3", (cyc - t_prev) >= 3, 64'd1);
            t_prev = cyc;
        end
        req = 2'b00;
        repeat (4) @(negedge clk);
        check("t6_ld_pulses", ld_count - ld_base, 64'd15);
        check("sb_empty", sb.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
